// File: rtl/uart_rx.sv
// UART receiver: oversampled 8-bit frames with run-time baud,
// parity and stop-bit configuration.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [31:0] baudrate,
  input  logic [1:0]  stop_bits,
  input  logic        parity_en,
  input  logic        parity_type,
  output logic [7:0]  data,
  output logic        valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rxs;
  logic        rxs_q;
  logic [31:0] div_c;
  logic        cfg_ok;
  logic [31:0] div_r;
  logic [31:0] cnt;
  logic        tick;
  logic [2:0]  nbit;
  logic [7:0]  sh;
  logic        par_bit;
  logic        par_en_r;
  logic        par_type_r;
  logic        two_stop_r;
  logic        second;
  logic        ferr_acc;
  logic        stop_fe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      rx_m  <= rx;
      rxs   <= rx_m;
      rxs_q <= rxs;
    end
  end

  always_comb begin
    div_c = '0;
    if (baudrate != '0)
      div_c = CLK_FREQ / baudrate;
  end

  assign cfg_ok  = div_c >= 32'd2;
  assign tick    = cnt <= 32'd1;
  assign stop_fe = ferr_acc | ~rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      div_r      <= '0;
      cnt        <= '0;
      nbit       <= '0;
      sh         <= '0;
      par_bit    <= 1'b0;
      par_en_r   <= 1'b0;
      par_type_r <= 1'b0;
      two_stop_r <= 1'b0;
      second     <= 1'b0;
      ferr_acc   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cfg_ok && rxs_q && !rxs) begin
            div_r      <= div_c;
            cnt        <= div_c >> 1;
            par_en_r   <= parity_en;
            par_type_r <= parity_type;
            two_stop_r <= stop_bits == 2'd1;
            second     <= 1'b0;
            ferr_acc   <= 1'b0;
            nbit       <= '0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (!tick) begin
            cnt <= cnt - 32'd1;
          end else if (!rxs) begin
            cnt   <= div_r;
            state <= DATA;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DATA: begin
          if (!tick) begin
            cnt <= cnt - 32'd1;
          end else begin
            sh   <= {rxs, sh[7:1]};
            cnt  <= div_r;
            nbit <= nbit + 3'd1;
            if (nbit == 3'd7)
              state <= par_en_r ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (!tick) begin
            cnt <= cnt - 32'd1;
          end else begin
            par_bit <= rxs;
            cnt     <= div_r;
            state   <= STOP;
          end
        end
        STOP: begin
          if (!tick) begin
            cnt <= cnt - 32'd1;
          end else if (two_stop_r && !second) begin
            second   <= 1'b1;
            ferr_acc <= ~rxs;
            cnt      <= div_r;
          end else begin
            // Data and both flags update together with the strobe
            data       <= sh;
            parity_err <= par_en_r & (^sh ^ par_bit ^ par_type_r);
            frame_err  <= stop_fe;
            valid      <= 1'b1;
            busy       <= stop_fe;
            state      <= stop_fe ? WAIT_IDLE : IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: vector table, corner sequences and
// randomized frames against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 25000000;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] baudrate;
  logic [1:0]  stop_bits;
  logic        parity_en;
  logic        parity_type;
  logic [7:0]  data;
  logic        valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .baudrate(baudrate),
    .stop_bits(stop_bits),
    .parity_en(parity_en),
    .parity_type(parity_type),
    .data(data),
    .valid(valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } cap_t;

  typedef struct {
    logic [7:0] d;
    bit         pen;
    bit         ptype;
    bit         pbit;
    logic [1:0] sb;
    bit         st0;
    bit         st1;
    logic [7:0] ed;
    bit         epe;
    bit         efe;
  } vec_t;

  cap_t capq[$];
  int   n_chk;
  int   n_fail;

  always @(negedge clk)
    if (valid)
      capq.push_back({data, parity_err, frame_err});

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] ed,
                             input bit epe, input bit efe);
    cap_t c;
    c = 'x;
    if (capq.size() > 0)
      c = capq.pop_front();
    check({name, ".data"}, 32'(c.d), 32'(ed));
    check({name, ".perr"}, 32'(c.pe), 32'(epe));
    check({name, ".ferr"}, 32'(c.fe), 32'(efe));
  endtask

  task automatic drive_bit(input bit b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int div, input logic [7:0] d,
                            input bit pen, input bit pbit,
                            input logic [1:0] sb, input bit st0,
                            input bit st1);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++)
      drive_bit(d[i], div);
    if (pen)
      drive_bit(pbit, div);
    drive_bit(st0, div);
    if (sb == 2'd1)
      drive_bit(st1, div);
    else if (sb[1])
      drive_bit(1'b1, div / 2);
    rx = 1'b1;
  endtask

  task automatic config_line(input logic [31:0] b, input logic [1:0] sb,
                             input bit pen, input bit pt);
    baudrate    = b;
    stop_bits   = sb;
    parity_en   = pen;
    parity_type = pt;
  endtask

  // Reference model: what a receiver must report for a frame
  function automatic cap_t model(input logic [7:0] d, input bit pen,
                                 input bit ptype, input bit pbit,
                                 input logic [1:0] sb, input bit st0,
                                 input bit st1);
    cap_t r;
    int   ones;
    bit   want;
    ones = 0;
    for (int i = 0; i < 8; i++)
      ones += int'(d[i]);
    want = ptype ? (ones % 2 == 0) : (ones % 2 == 1);
    r.d  = d;
    r.pe = pen && (pbit != want);
    r.fe = (sb == 2'd1) ? (!st0 || !st1) : !st0;
    return r;
  endfunction

  vec_t vecs[9];

  initial begin
    cap_t e;
    int   div;
    int   mdiv;
    logic [31:0] b;
    logic [7:0]  hello[13];

    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    rx     = 1'b1;
    config_line(32'd115200, 2'd0, 1'b0, 1'b0);

    vecs[0] = '{8'h55, 0, 0, 0, 2'd0, 1, 1, 8'h55, 0, 0};
    vecs[1] = '{8'hA3, 1, 0, 0, 2'd1, 1, 1, 8'hA3, 0, 0};
    vecs[2] = '{8'hA3, 1, 0, 1, 2'd1, 1, 1, 8'hA3, 1, 0};
    vecs[3] = '{8'hA3, 1, 1, 1, 2'd1, 1, 1, 8'hA3, 0, 0};
    vecs[4] = '{8'h0F, 0, 0, 0, 2'd0, 0, 1, 8'h0F, 0, 1};
    vecs[5] = '{8'h3C, 0, 0, 0, 2'd0, 1, 1, 8'h3C, 0, 0};
    vecs[6] = '{8'h00, 0, 0, 0, 2'd2, 1, 1, 8'h00, 0, 0};
    vecs[7] = '{8'hFF, 1, 1, 0, 2'd3, 1, 1, 8'hFF, 1, 0};
    vecs[8] = '{8'h81, 0, 0, 0, 2'd1, 1, 0, 8'h81, 0, 1};

    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    repeat (3) @(negedge clk);
    check("rst.data", 32'(data), 32'h0);
    check("rst.valid", 32'(valid), 32'h0);
    check("rst.perr", 32'(parity_err), 32'h0);
    check("rst.ferr", 32'(frame_err), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic 8N1 at 115200
    send_frame(217, 8'h55, 0, 0, 2'd0, 1, 1);
    repeat (600) @(negedge clk);
    check("8n1.count", 32'(capq.size()), 32'd1);
    check_frame("8n1", 8'h55, 0, 0);
    check("8n1.busy", 32'(busy), 32'h0);

    // Glitch rejection
    drive_bit(1'b0, 30);
    check("glitch.busy_hi", 32'(busy), 32'h1);
    drive_bit(1'b0, 20);
    rx = 1'b1;
    repeat (108 + 6) @(negedge clk);
    check("glitch.busy_lo", 32'(busy), 32'h0);
    check("glitch.count", 32'(capq.size()), 32'd0);

    // Vector table at 1 Mbaud (div 25)
    foreach (vecs[i]) begin
      config_line(32'd1000000, vecs[i].sb, vecs[i].pen, vecs[i].ptype);
      send_frame(25, vecs[i].d, vecs[i].pen, vecs[i].pbit, vecs[i].sb,
                 vecs[i].st0, vecs[i].st1);
      repeat (75) @(negedge clk);
      check($sformatf("vec%0d.count", i), 32'(capq.size()), 32'd1);
      check_frame($sformatf("vec%0d", i), vecs[i].ed, vecs[i].epe,
                  vecs[i].efe);
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'h0);
    end

    // Back-to-back frames, no idle gap
    config_line(32'd1000000, 2'd0, 1'b0, 1'b0);
    foreach (hello[i])
      send_frame(25, hello[i], 0, 0, 2'd0, 1, 1);
    repeat (75) @(negedge clk);
    check("hello.count", 32'(capq.size()), 32'd13);
    foreach (hello[i])
      check_frame($sformatf("hello%0d", i), hello[i], 0, 0);

    // Framing error followed by a break
    send_frame(25, 8'h0F, 0, 0, 2'd0, 0, 1);
    rx = 1'b0;
    repeat (20 * 25) @(negedge clk);
    check("break.count", 32'(capq.size()), 32'd1);
    check_frame("break.first", 8'h0F, 0, 1);
    check("break.busy", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    send_frame(25, 8'h3C, 0, 0, 2'd0, 1, 1);
    repeat (75) @(negedge clk);
    check("break.after_cnt", 32'(capq.size()), 32'd1);
    check_frame("break.after", 8'h3C, 0, 0);

    // Unusable baud settings leave the line ignored
    config_line(32'd0, 2'd0, 1'b0, 1'b0);
    send_frame(25, 8'h12, 0, 0, 2'd0, 1, 1);
    config_line(32'd20000000, 2'd0, 1'b0, 1'b0);
    send_frame(25, 8'h34, 0, 0, 2'd0, 1, 1);
    repeat (75) @(negedge clk);
    check("nobaud.count", 32'(capq.size()), 32'd0);
    check("nobaud.busy", 32'(busy), 32'h0);

    // Reset after data bit 3 of 0xFF
    config_line(32'd1000000, 2'd0, 1'b0, 1'b0);
    drive_bit(1'b0, 25);
    for (int i = 0; i < 4; i++)
      drive_bit(1'b1, 25);
    check("rstmid.busy_pre", 32'(busy), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("rstmid.data", 32'(data), 32'h0);
    check("rstmid.busy", 32'(busy), 32'h0);
    check("rstmid.perr", 32'(parity_err), 32'h0);
    check("rstmid.ferr", 32'(frame_err), 32'h0);
    check("rstmid.valid", 32'(valid), 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("rstmid.count", 32'(capq.size()), 32'd0);
    send_frame(25, 8'hC3, 0, 0, 2'd0, 1, 1);
    repeat (75) @(negedge clk);
    check("rstmid.after_cnt", 32'(capq.size()), 32'd1);
    check_frame("rstmid.after", 8'hC3, 0, 0);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      automatic logic [7:0] d   = 8'($urandom);
      automatic bit         pen = 1'($urandom);
      automatic bit         pt  = 1'($urandom);
      automatic bit         pb  = 1'($urandom);
      automatic logic [1:0] sb  = 2'($urandom);
      automatic bit         s0  = $urandom_range(0, 5) != 0;
      automatic bit         s1  = $urandom_range(0, 5) != 0;
      div  = $urandom_range(8, 40);
      b    = 32'(CLK_FREQ / div);
      mdiv = int'(CLK_FREQ / b);
      config_line(b, sb, pen, pt);
      send_frame(mdiv, d, pen, pb, sb, s0, s1);
      repeat (3 * mdiv) @(negedge clk);
      e = model(d, pen, pt, pb, sb, s0, s1);
      check($sformatf("rnd%0d.count", n), 32'(capq.size()), 32'd1);
      check_frame($sformatf("rnd%0d", n), e.d, e.pe, e.fe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the downstream counterpart of `uart_tx`. It oversamples the serial line with the system clock and recovers 8-bit frames (LSB first) using the same run-time baudrate, stop-bit and parity configuration as the transmitter. Each byte is delivered with a one-cycle `valid` strobe plus parity and framing error flags. It feeds the receive-side byte buffer, and the loopback bench uses it as the checker for `uart_tx` output.

## Interface
- `CLK_FREQ`, 25000000, system clock frequency in Hz, used to derive the bit period.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `baudrate`  in  32  bit rate in bit/s.
- `stop_bits`  in  2  0 = 1 stop bit, 1 = 2 stop bits, 2 or 3 = 1.5 stop bits.
- `parity_en`  in  1  parity bit present after the data bits.
- `parity_type`  in  1  0 = even, 1 = odd.
- `data`  out  8  last received byte.
- `valid`  out  1  one-cycle strobe when `data` and the error flags update.
- `parity_err`  out  1  parity mismatch on the last byte.
- `frame_err`  out  1  a sampled stop bit was low on the last byte.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, reset value 1. All logic uses the synchronized value `rxs`.
- **Divisor:** `div = CLK_FREQ / baudrate` (integer truncation), with `half = div >> 1`.
  - Both are latched into 32-bit registers on start detection, so configuration changes mid-frame have no effect on that frame.
  - If `baudrate == 0` or the computed `div < 2`, the block stays in IDLE and ignores the line.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE:** a falling edge on `rxs` (previous 1, current 0) loads the bit counter with `half` and moves to START.
- **START:** at counter expiry, sample `rxs`.
  - If 0: go to DATA with the counter set to `div`.
  - If 1: false start (glitch); return to IDLE with no output.
- **DATA:** sample every `div` cycles into a shift register, LSB first. After 8 samples, go to PARITY if `parity_en` is set, otherwise STOP.
- **PARITY:** sample after `div` cycles. `parity_err = (^data ^ rx_parity ^ parity_type) != 0`.
- **STOP:** sample the first stop bit after `div` cycles.
  - When `stop_bits == 1`, also sample a second stop bit `div` cycles later.
  - For 1.5 stop bits, only the first is sampled.
  - `frame_err` is set if any sampled stop bit is 0.
- **Completion:** after the last stop sample, update `data`, `parity_err` and `frame_err` together and pulse `valid`.
  - On a clean frame, go to IDLE.
  - If `frame_err` is set, go to WAIT_IDLE.
- **WAIT_IDLE:** hold until `rxs == 1`, then go to IDLE. This prevents a break condition from being received as repeated 0x00 frames.
- **Frames with errors** are still delivered: `valid` = 1 with the flag(s) set.
- `parity_err` is 0 whenever `parity_en` = 0.

## Timing
- **Reset values:** `data` = 0x00, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0, state IDLE, synchronizer flops = 1.
- **Reset mid-frame:** all of the above apply immediately (asynchronous). The partial byte is discarded and no `valid` is emitted.
- **Latency from a falling edge on the `rx` pin:**
  - Edge detect occurs 2–3 clocks later (synchronizer).
  - Start-bit sample is `half` cycles after edge detect.
  - Data bit k (0..7) is sampled `half + (k+1)*div` cycles after edge detect.
  - `valid` rises 1 clock after the last stop sample and lasts exactly 1 clock.
- **Flag stability:** `data` and the flags are stable from the `valid` cycle until the next `valid`.
- **Re-arming:** IDLE is re-entered directly after a clean frame, so a start bit beginning half a bit after the stop-bit sample is caught (back-to-back frames at 1 stop bit).
- **Back-to-back frames:** no dead time beyond the synchronizer delay. Consecutive frames from `uart_tx` are all received.
- **`busy`:** asserts the cycle after edge detect and deasserts on return to IDLE.

## Test plan
- **Basic 8N1:** 8N1 at 115200 baud (`div` = 217, `half` = 108); drive 0x55 → exactly one `valid` pulse, `data` = 0x55, `parity_err` = `frame_err` = 0, `busy` low afterwards.
- **Loopback from `uart_tx`:** connect to `uart_tx` `tx` and send "Hello, World!" (13 bytes, 8N1) → 13 `valid` pulses with `data` 48 65 6C 6C 6F 2C 20 57 6F 72 6C 64 21 in order, no error flags.
- **Parity:**
  - Even parity, 2 stop bits, 0xA3 with parity bit 0 → `data` = 0xA3, `parity_err` = 0.
  - Same frame with parity bit forced to 1 → `valid` = 1, `parity_err` = 1.
  - Odd parity with parity bit 1 → `parity_err` = 0.
- **Glitch rejection:** `rx` low for 50 clocks, then high → no `valid`; `busy` returns to 0 within `half` + 3 clocks.
- **Framing error and break:**
  - Frame 0x0F with stop bit forced 0 → `valid`, `data` = 0x0F, `frame_err` = 1.
  - Then hold `rx` low for 20 bit times → no further `valid`.
  - Release `rx`, then send 0x3C → `data` = 0x3C, `frame_err` = 0.
- **Reset mid-frame:** assert `rst` after data bit 3 of 0xFF → all outputs at reset values immediately, no `valid`. After release, frame 0xC3 → `data` = 0xC3.
